// File: rtl/lif_param_loader_pkg.sv
// lif_param_loader_pkg: FSM encodings, frame field positions and the frame checksum.
package lif_param_loader_pkg;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_B1   = 3'd1;
    localparam logic [2:0] S_B2   = 3'd2;
    localparam logic [2:0] S_B3   = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;
    localparam logic [2:0] S_PEND = 3'd5;
    localparam logic [7:0] HEADER_DEF = 8'hA5;
    localparam int WA_LSB = 5;
    localparam int WB_LSB = 2;
    localparam int LK_LSB = 0;
    function automatic logic [7:0] frame_chk(input logic [7:0] h, b1, b2, b3);
        return h ^ b1 ^ b2 ^ b3;
    endfunction
endpackage

// File: rtl/lif_param_loader_timeout.sv
// lif_param_loader_timeout: inter-byte idle counter; expires on the TIMEOUT_CYC-th idle cycle.
module lif_param_loader_timeout #(
    parameter int TO_W        = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    logic [TO_W-1:0] r_cnt;
    assign o_expire = i_en && !i_clr && r_cnt == TO_W'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_en) r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/lif_param_loader.sv
// lif_param_loader: validates 5-byte config frames and atomically commits them to the LIF neuron.
module lif_param_loader
    import lif_param_loader_pkg::*;
#(
    parameter logic [7:0] HEADER      = HEADER_DEF,
    parameter int         TIMEOUT_CYC = 255,
    parameter int         TO_W        = 8,
    parameter int         ERR_W       = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_valid,
    input  logic [7:0]       cfg_byte,
    output logic             cfg_ready,
    input  logic             commit_hold,
    output logic [2:0]       weight_a,
    output logic [2:0]       weight_b,
    output logic [1:0]       leak_config,
    output logic [7:0]       threshold_min,
    output logic [7:0]       threshold_max,
    output logic             params_ready,
    output logic             param_update,
    output logic             frame_err,
    output logic [ERR_W-1:0] err_count
);
    logic [2:0]       r_state, w_next;
    logic [7:0]       r_b1, r_min, r_max;
    logic [2:0]       r_wa, r_wb;
    logic [1:0]       r_lk;
    logic [7:0]       r_thr_min, r_thr_max;
    logic             r_ready, r_update, r_err;
    logic [ERR_W-1:0] r_err_cnt;
    logic             w_xfer, w_good, w_commit, w_err, w_expire, w_in_frame;

    assign cfg_ready  = r_state != S_PEND;
    assign w_xfer     = cfg_valid && cfg_ready;
    assign w_in_frame = r_state != S_IDLE && r_state != S_PEND;
    assign w_good     = cfg_byte == frame_chk(HEADER, r_b1, r_min, r_max) && r_min <= r_max;
    assign w_commit   = (r_state == S_CHK && w_xfer && w_good && !commit_hold) ||
                        (r_state == S_PEND && !commit_hold);
    assign w_err      = (r_state == S_CHK && w_xfer && !w_good) || w_expire;

    lif_param_loader_timeout #(.TO_W(TO_W), .TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_xfer || !w_in_frame),
        .i_en    (w_in_frame && !w_xfer),
        .o_expire(w_expire)
    );

    always_comb begin
        w_next = r_state;
        if (w_expire) w_next = S_IDLE;
        else case (r_state)
            S_IDLE:  if (w_xfer && cfg_byte == HEADER) w_next = S_B1;
            S_B1:    if (w_xfer) w_next = S_B2;
            S_B2:    if (w_xfer) w_next = S_B3;
            S_B3:    if (w_xfer) w_next = S_CHK;
            S_CHK:   if (w_xfer) w_next = (w_good && commit_hold) ? S_PEND : S_IDLE;
            S_PEND:  if (!commit_hold) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_b1    <= '0;
            r_min   <= '0;
            r_max   <= '0;
        end else begin
            r_state <= w_next;
            if (w_xfer && r_state == S_B1) r_b1 <= cfg_byte;
            if (w_xfer && r_state == S_B2) r_min <= cfg_byte;
            if (w_xfer && r_state == S_B3) r_max <= cfg_byte;
        end
    end

    // live set only moves on a commit edge, so the neuron never sees a partial frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wa      <= '0;
            r_wb      <= '0;
            r_lk      <= '0;
            r_thr_min <= '0;
            r_thr_max <= '0;
            r_ready   <= 1'b0;
            r_update  <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_update <= w_commit;
            if (w_commit) begin
                r_wa      <= r_b1[WA_LSB +: 3];
                r_wb      <= r_b1[WB_LSB +: 3];
                r_lk      <= r_b1[LK_LSB +: 2];
                r_thr_min <= r_min;
                r_thr_max <= r_max;
                r_ready   <= 1'b1;
                r_err     <= 1'b0;
            end else if (w_err) begin
                r_err <= 1'b1;
                if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign weight_a      = r_wa;
    assign weight_b      = r_wb;
    assign leak_config   = r_lk;
    assign threshold_min = r_thr_min;
    assign threshold_max = r_thr_max;
    assign params_ready  = r_ready;
    assign param_update  = r_update;
    assign frame_err     = r_err;
    assign err_count     = r_err_cnt;
endmodule
